// File: rtl/key_event_queue.sv
// key_event_queue
//
// Turns decoder updates for the five game keys into 3-bit command events.
// Arrow keys that stay held produce typematic repeat events. All events go
// into a small FIFO, which the game FSM drains with a valid/ack handshake.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   key_down     512-bit key level vector, indexed by {extend, scancode}
//   last_change  {extend, scancode} of the most recent decoder update
//   key_valid    one-cycle strobe: last_change/key_down just updated
//   key_num      head-of-queue command (0 up, 1 down, 2 left, 3 right, 4 enter); 0 when empty
//   key          queue non-empty, key_num valid
//   key_ack      pop the head entry (ignored when empty)
//   held         registered levels {enter, right, left, down, up}
//   overflow     sticky: an event was dropped because the queue was full
//
// Repeat FSM
//   state  | meaning
//   IDLE   | no arrow being repeated
//   DELAY  | arrow pressed, waiting REPEAT_DELAY cycles for the first repeat
//   REPEAT | emitting a repeat every REPEAT_PERIOD cycles
module key_event_queue #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    output logic [2:0]   key_num,
    output logic         key,
    input  logic         key_ack,
    output logic [4:0]   held,
    output logic         overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(RMAX);

    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [AW:0]   PTR_ONE     = (AW+1)'(1);

    localparam logic [8:0] SC_UP       = 9'h175;
    localparam logic [8:0] SC_DOWN     = 9'h172;
    localparam logic [8:0] SC_LEFT     = 9'h16B;
    localparam logic [8:0] SC_RIGHT    = 9'h174;
    localparam logic [8:0] SC_ENTER    = 9'h05A;
    localparam logic [8:0] SC_KP_ENTER = 9'h15A;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    rep_state_t    state;
    logic [1:0]    rep_cmd;
    logic [CW-1:0] counter;

    logic          map_hit;
    logic [2:0]    map_cmd;
    logic          press;
    logic          arrow_press;
    logic          rep_key_down;
    logic          rep_fire;

    always_comb begin
        map_hit = 1'b1;
        map_cmd = 3'd0;
        case (last_change)
            SC_UP:                 map_cmd = 3'd0;
            SC_DOWN:               map_cmd = 3'd1;
            SC_LEFT:               map_cmd = 3'd2;
            SC_RIGHT:              map_cmd = 3'd3;
            SC_ENTER, SC_KP_ENTER: map_cmd = 3'd4;
            default:               map_hit = 1'b0;
        endcase
    end

    assign press       = key_valid & map_hit & key_down[last_change];
    assign arrow_press = press & ~map_cmd[2];

    always_comb begin
        rep_key_down = 1'b0;
        case (rep_cmd)
            2'd0:    rep_key_down = key_down[SC_UP];
            2'd1:    rep_key_down = key_down[SC_DOWN];
            2'd2:    rep_key_down = key_down[SC_LEFT];
            default: rep_key_down = key_down[SC_RIGHT];
        endcase
    end

    // Repeat expiry while the arrow is still down; a press in the same cycle
    // takes the single enqueue slot (see ev_cmd below).
    assign rep_fire = rep_key_down &
                      (((state == DELAY)  && (counter == DELAY_LAST)) ||
                       ((state == REPEAT) && (counter == PERIOD_LAST)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rep_cmd <= 2'd0;
            counter <= '0;
        end else if (arrow_press) begin
            state   <= DELAY;
            rep_cmd <= map_cmd[1:0];
            counter <= '0;
        end else if ((state != IDLE) && !rep_key_down) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                DELAY: begin
                    if (counter == DELAY_LAST) begin
                        state   <= REPEAT;
                        counter <= '0;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (counter == PERIOD_LAST) counter <= '0;
                    else                        counter <= counter + CNT_ONE;
                end
                default: counter <= '0;
            endcase
        end
    end

    logic [2:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        ev_valid;
    logic [2:0]  ev_cmd;
    logic        do_pop;
    logic        do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev_valid = press | rep_fire;
    assign ev_cmd   = press ? map_cmd : {1'b0, rep_cmd};
    assign do_pop   = key_ack & ~empty;
    assign do_push  = ev_valid & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            held     <= 5'd0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (ev_valid && full && !do_pop) overflow <= 1'b1;
            held <= {key_down[SC_ENTER] | key_down[SC_KP_ENTER],
                     key_down[SC_RIGHT], key_down[SC_LEFT],
                     key_down[SC_DOWN], key_down[SC_UP]};
        end
    end

    // Storage needs no reset: the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= ev_cmd;
    end

    assign key     = ~empty;
    assign key_num = empty ? 3'd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;
    localparam int RD    = 8;
    localparam int RP    = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [511:0] key_down = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic         key_ack = 1'b0;
    logic [2:0]   key_num;
    logic         key;
    logic [4:0]   held;
    logic         overflow;

    always #5 clk = ~clk;

    key_event_queue #(
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_down   (key_down),
        .last_change(last_change),
        .key_valid  (key_valid),
        .key_num    (key_num),
        .key        (key),
        .key_ack    (key_ack),
        .held       (held),
        .overflow   (overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a queue of commands plus an absolute-time repeat schedule.
    int       q[$];
    bit       m_ovf;
    bit [4:0] m_held;
    bit       m_active;
    int       m_rep;
    int       m_next;
    int       cyc = 0;

    function automatic int map_code(input logic [8:0] c);
        case (c)
            9'h175:         return 0;
            9'h172:         return 1;
            9'h16B:         return 2;
            9'h174:         return 3;
            9'h05A, 9'h15A: return 4;
            default:        return -1;
        endcase
    endfunction

    function automatic logic [8:0] code_of(input int cmd);
        case (cmd)
            0:       return 9'h175;
            1:       return 9'h172;
            2:       return 9'h16B;
            default: return 9'h174;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_held   = 5'd0;
        m_active = 1'b0;
        m_rep    = 0;
        m_next   = 0;
    endtask

    task automatic model_edge();
        int cmd;
        int ev;
        bit press;
        bit fire;
        bit pop;
        cmd   = map_code(last_change);
        press = key_valid && (cmd >= 0) && key_down[last_change];
        fire  = 1'b0;
        if (press && cmd < 4) begin
            m_active = 1'b1;
            m_rep    = cmd;
            m_next   = cyc + RD;
        end else if (m_active) begin
            if (!key_down[code_of(m_rep)]) m_active = 1'b0;
            else if (cyc == m_next) begin
                fire   = 1'b1;
                m_next = cyc + RP;
            end
        end
        ev  = press ? cmd : (fire ? m_rep : -1);
        pop = key_ack && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (ev >= 0) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1'b1;
        end
        m_held = {key_down[9'h05A] | key_down[9'h15A], key_down[9'h174],
                  key_down[9'h16B], key_down[9'h172], key_down[9'h175]};
    endtask

    task automatic compare();
        bit       e_key;
        bit [2:0] e_num;
        e_key = (q.size() > 0);
        e_num = (q.size() > 0) ? 3'(q[0]) : 3'd0;
        vectors++;
        if (key !== e_key || key_num !== e_num || held !== m_held || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL model cycle %0d: key/key_num/held/overflow = %b/%0d/%b/%b, required %b/%0d/%b/%b",
                     cyc, key, key_num, held, overflow, e_key, e_num, m_held, m_ovf);
        end
    endtask

    task automatic check(input string name, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic cycle(input logic kv, input logic [8:0] lc, input logic ack);
        key_valid   = kv;
        last_change = lc;
        key_ack     = ack;
        @(posedge clk);
        if (rst) model_edge();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, 1'b0);
    endtask

    task automatic press_key(input logic [8:0] c, input logic ack);
        key_down[c] = 1'b1;
        cycle(1'b1, c, ack);
    endtask

    task automatic release_key(input logic [8:0] c);
        key_down[c] = 1'b0;
        cycle(1'b1, c, 1'b0);
    endtask

    task automatic pop_one();
        cycle(1'b0, 9'h000, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        idle(2);
        rst = 1'b1;
    endtask

    logic [8:0] codes [6];

    initial begin
        codes[0] = 9'h175; codes[1] = 9'h172; codes[2] = 9'h16B;
        codes[3] = 9'h174; codes[4] = 9'h05A; codes[5] = 9'h15A;
        model_reset();
        idle(3);
        check("reset key", int'(key), 0);
        check("reset overflow", int'(overflow), 0);
        rst = 1'b1;

        // 1: up press, then ack
        press_key(9'h175, 1'b0);
        check("t1 key", int'(key), 1);
        check("t1 key_num", int'(key_num), 0);
        check("t1 held", int'(held), 5'b00001);
        pop_one();
        check("t1 key after ack", int'(key), 0);
        release_key(9'h175);

        // 2: hold left, fill queue, overflow, drain
        press_key(9'h16B, 1'b0);
        idle(30);
        check("t2 overflow", int'(overflow), 1);
        release_key(9'h16B);
        for (int i = 0; i < 4; i++) begin
            check("t2 drain key_num", int'(key_num), 2);
            check("t2 drain key", int'(key), 1);
            pop_one();
        end
        check("t2 empty", int'(key), 0);
        do_reset();

        // 3: right pressed, released at cycle 5
        press_key(9'h174, 1'b0);
        idle(4);
        key_down[9'h174] = 1'b0;
        cycle(1'b0, 9'h000, 1'b0);
        idle(20);
        check("t3 key_num", int'(key_num), 3);
        pop_one();
        check("t3 single event", int'(key), 0);

        // 4: down then up while down held; up repeat at +8
        press_key(9'h172, 1'b0);
        idle(5);
        press_key(9'h175, 1'b0);
        check("t4 head", int'(key_num), 1);
        idle(8);
        key_down[9'h175] = 1'b0;
        key_down[9'h172] = 1'b0;
        cycle(1'b0, 9'h000, 1'b0);
        check("t4 ev0", int'(key_num), 1); pop_one();
        check("t4 ev1", int'(key_num), 0); pop_one();
        check("t4 ev2 up repeat", int'(key_num), 0); pop_one();
        check("t4 empty", int'(key), 0);

        // 5: keypad enter held, single event
        press_key(9'h15A, 1'b0);
        idle(39);
        check("t5 key_num", int'(key_num), 4);
        check("t5 held", int'(held), 5'b10000);
        pop_one();
        check("t5 no repeat", int'(key), 0);
        release_key(9'h15A);

        // 6: full queue, press with simultaneous ack, then reset mid-REPEAT
        for (int i = 0; i < 4; i++) begin
            press_key(9'h05A, 1'b0);
            release_key(9'h05A);
        end
        press_key(9'h16B, 1'b1);
        check("t6 overflow after pop+push", int'(overflow), 0);
        check("t6 key", int'(key), 1);
        idle(10);
        #2 rst = 1'b0;
        #1;
        check("t6 async key", int'(key), 0);
        check("t6 async overflow", int'(overflow), 0);
        check("t6 async held", int'(held), 0);
        model_reset();
        idle(2);
        rst = 1'b1;
        idle(20);
        check("t6 held key no events", int'(key), 0);
        key_down = '0;
        idle(2);

        // Randomized phase against the model
        for (int n = 0; n < 3000; n++) begin
            logic       kv;
            logic [8:0] lc;
            logic       ack;
            kv  = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 3) == 0);
            lc  = 9'h000;
            if (kv) begin
                if ($urandom_range(0, 4) == 0) lc = 9'($urandom_range(0, 511));
                else lc = codes[$urandom_range(0, 5)];
                key_down[lc] = ($urandom_range(0, 9) < 6);
            end
            cycle(kv, lc, ack);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                idle(2);
                rst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of KeyboardDecoder. Consumes its key_down / last_change / key_valid outputs and turns the five game keys into 3-bit command events.
- The game keys are up, down, left, right and enter.
- Generates typematic auto-repeat for held arrow keys.
- Buffers events in a small FIFO that the game FSM drains with a valid/ack handshake.

Parameters:
REPEAT_DELAY, 50_000_000, cycles an arrow must stay held after its press event before the first repeat event (0.5 s at 100 MHz); must be >= 2.
REPEAT_PERIOD, 10_000_000, cycles between successive repeat events; must be >= 2.
FIFO_DEPTH, 4, event queue entries; power of 2, >= 2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
key_down  input  512  level vector from KeyboardDecoder, indexed by {extend, scancode}.
last_change  input  9  {extend, scancode} of the most recent decoder update.
key_valid  input  1  one-cycle strobe; last_change and key_down have just been updated.
key_num  output  3  head-of-queue command: 0 up, 1 down, 2 left, 3 right, 4 enter; 5-7 never produced.
key  output  1  high while the queue is non-empty; key_num is valid.
key_ack  input  1  consumer pop; honoured only when key=1.
held  output  5  registered level of the keys {enter, right, left, down, up}, taken from key_down.
overflow  output  1  sticky; set when an event is dropped because the queue is full.

Behaviour:
- Reset (rst=0, asynchronous): queue empty, key=0, key_num=0, held=0, overflow=0, repeat FSM in IDLE, counter=0.
- Key map, on last_change:
  - 9'h175 up, 9'h172 down, 9'h16B left, 9'h174 right.
  - 9'h05A and 9'h15A both map to enter.
  - All other codes are ignored.
- Press event: key_valid=1, mapped code, key_down[last_change]=1. Enqueue the command on the next clk edge.
  - Latency: key=1 one cycle after the key_valid strobe, if the queue was empty.
- Release (key_down[last_change]=0): no event is enqueued; only affects repeat.
- held: registered copy of key_down at the six mapped indices. The enter bit is the OR of 9'h05A and 9'h15A. One-cycle latency.
- Repeat FSM, states IDLE / DELAY / REPEAT; rep_cmd holds one arrow code.
  - IDLE: on an arrow press, go to DELAY, set rep_cmd to that arrow, counter=0.
  - DELAY: counter increments each cycle. At counter = REPEAT_DELAY-1, enqueue rep_cmd, counter=0, go to REPEAT.
  - REPEAT: at counter = REPEAT_PERIOD-1, enqueue rep_cmd, counter=0.
  - In DELAY or REPEAT, if rep_cmd's key_down bit reads 0, go to IDLE immediately; no event that cycle.
  - A new arrow press in any state restarts DELAY with the new rep_cmd; last-pressed arrow wins.
  - An enter press never enters or disturbs the repeat FSM.
- Simultaneous press and repeat-expiry in the same cycle: only the press event is enqueued, and the repeat restarts.
- At most one enqueue per cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; the full/empty distinction comes from the pointer MSB.
  - Pop when key_ack=1 and not empty.
  - Push when an event is present and (not full, or a pop happens the same cycle).
  - Push when full with no pop: event dropped, overflow <= 1. Queue contents are unchanged.
  - key_ack while empty: ignored.
- key_num is driven combinationally from the head entry; it is 0 when empty.
- Reset asserted mid-repeat or with a non-empty queue clears everything. After reset, keys already held generate no events until they are re-pressed.

Test Plan (REPEAT_DELAY=8, REPEAT_PERIOD=4, FIFO_DEPTH=4):
1. Strobe key_valid with last_change=9'h175, key_down[9'h175]=1 -> next cycle key=1, key_num=0, held=5'b00001. key_ack=1 for one cycle -> key=0.
2. Hold left (9'h16B) for 30 cycles, no ack -> press event plus repeats at +8 and +12 cycles after the press. Queue fills at 4 entries, overflow=1. The dequeue order is 2,2,2,2.
3. Press right, then release at cycle 5 -> exactly one event (key_num=3); FSM back in IDLE; no repeat later.
4. Press down, then press up at cycle 6 while down is still held -> events 1,0. The next repeat is an up at 8 cycles after the up press; no down repeat follows.
5. Press 9'h15A (keypad enter) and hold 40 cycles -> a single event, key_num=4; held[4]=1; no repeats.
6. Queue full with key_ack=1 in the same cycle as a new press -> pop and push both occur; overflow stays 0. Then pull rst low mid-REPEAT -> key=0, overflow=0, held=0 immediately.
